// File: rtl/seq_seg_player.sv
`default_nettype none
// ============================================================================
// Module   : seq_seg_player
// Brief    : Steps through a packed digit table at a prescaled rate and shows
//            the current digit on an active-low 7-segment display.
// Revision : 1.0
// ============================================================================
module seq_seg_player #(
    parameter int                 STEPS = 6,
    parameter int                 CNT_W = 3,
    parameter int                 DIV   = 50000000,
    parameter logic [STEPS*4-1:0] SEQ   = {4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd0}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             en,
    input  logic             mode,
    input  logic             dir,
    output logic [CNT_W-1:0] count,
    output logic [6:0]       seg,
    output logic             dpt,
    output logic             done
);

    localparam int                 c_pre_w   = $clog2(DIV);
    localparam logic [c_pre_w-1:0] c_pre_max = c_pre_w'(DIV - 1);
    localparam logic [CNT_W-1:0]   c_last    = CNT_W'(STEPS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [c_pre_w-1:0] r_pre, w_pre_nxt;
    logic [CNT_W-1:0]   r_count, w_count_nxt;
    logic               r_dir, w_dir_nxt;
    logic [6:0]         r_seg, w_seg_nxt;
    logic               r_dpt, w_dpt_nxt;
    logic               w_tick;
    logic               w_at_term;
    logic [3:0]         w_digit;

    assign w_tick    = (r_state == S_RUN) && en && (r_pre == c_pre_max);
    assign w_at_term = dir ? (r_count == '0) : (r_count == c_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_pre   <= '0;
            r_count <= '0;
            r_dir   <= 1'b0;
            r_seg   <= 7'b1111111;
            r_dpt   <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_pre   <= w_pre_nxt;
            r_count <= w_count_nxt;
            r_dir   <= w_dir_nxt;
            r_seg   <= w_seg_nxt;
            r_dpt   <= w_dpt_nxt;
        end
    end

    // start restarts from any state and wins over a coincident tick
    always_comb begin
        w_state_nxt = r_state;
        w_pre_nxt   = r_pre;
        w_count_nxt = r_count;
        w_dir_nxt   = r_dir;
        if (start) begin
            w_state_nxt = S_RUN;
            w_pre_nxt   = '0;
            w_count_nxt = dir ? c_last : '0;
            w_dir_nxt   = dir;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_tick) begin
                        w_pre_nxt = '0;
                        w_dir_nxt = dir;
                        if (w_at_term) begin
                            if (mode) w_state_nxt = S_DONE;
                            else      w_count_nxt = dir ? c_last : '0;
                        end else begin
                            w_count_nxt = dir ? (r_count - 1'b1) : (r_count + 1'b1);
                        end
                    end else if (en) begin
                        w_pre_nxt = r_pre + 1'b1;
                    end
                end
                S_IDLE, S_DONE: ;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    assign w_digit = 4'(SEQ >> {r_count, 2'b00});

    // Display pipeline stage: decodes the present count/state for the next cycle
    always_comb begin
        w_seg_nxt = 7'b1111111;
        w_dpt_nxt = 1'b1;
        if (r_state != S_IDLE) begin
            if ((r_count > c_last) || (w_digit > 4'd9)) begin
                w_seg_nxt = 7'b0000000;
                w_dpt_nxt = 1'b0;
            end else begin
                case (w_digit)
                    4'd0:    w_seg_nxt = 7'b1000000;
                    4'd1:    w_seg_nxt = 7'b1111001;
                    4'd2:    w_seg_nxt = 7'b0100100;
                    4'd3:    w_seg_nxt = 7'b0110000;
                    4'd4:    w_seg_nxt = 7'b0011001;
                    4'd5:    w_seg_nxt = 7'b0010010;
                    4'd6:    w_seg_nxt = 7'b0000010;
                    4'd7:    w_seg_nxt = 7'b1111000;
                    4'd8:    w_seg_nxt = 7'b0000000;
                    4'd9:    w_seg_nxt = 7'b0010000;
                    default: w_seg_nxt = 7'b0000000;
                endcase
                w_dpt_nxt = (r_count == (r_dir ? '0 : c_last)) ? 1'b0 : 1'b1;
            end
        end
    end

    assign count = r_count;
    assign seg   = r_seg;
    assign dpt   = r_dpt;
    assign done  = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_seq_seg_player.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_seg_player
// Brief    : Scoreboard bench for seq_seg_player with a step-level reference model.
// Revision : 1.0
// ============================================================================
module tb_seq_seg_player;

    localparam int STEPS = 6;
    localparam int CNT_W = 3;
    localparam int DIV   = 4;

    logic             clk = 1'b0;
    logic             rst, start, en, mode, dir;
    logic [CNT_W-1:0] count;
    logic [6:0]       seg;
    logic             dpt, done;

    seq_seg_player #(
        .STEPS(STEPS),
        .CNT_W(CNT_W),
        .DIV  (DIV),
        .SEQ  (24'h001230)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .en   (en),
        .mode (mode),
        .dir  (dir),
        .count(count),
        .seg  (seg),
        .dpt  (dpt),
        .done (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CNT_W-1:0] count;
        logic [6:0]       seg;
        logic             dpt;
        logic             done;
    } exp_t;

    exp_t q[$];
    int   compared   = 0;
    int   mismatched = 0;

    int         digits[STEPS] = '{0, 3, 2, 1, 0, 0};
    logic [6:0] pat[10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    // Reference model: playing / finished flags, step index, cycles spent in the step
    bit m_play, m_fin, m_ddir;
    int m_idx, m_el;

    task automatic compare(input string nm, input exp_t e);
        compared++;
        if (count !== e.count || seg !== e.seg || dpt !== e.dpt || done !== e.done) begin
            mismatched++;
            $display("FAIL %s t=%0t: got count=%0d seg=%b dpt=%b done=%b, want count=%0d seg=%b dpt=%b done=%b",
                     nm, $time, count, seg, dpt, done, e.count, e.seg, e.dpt, e.done);
        end
    endtask

    task automatic model_reset();
        m_play = 0; m_fin = 0; m_ddir = 0; m_idx = 0; m_el = 0;
    endtask

    task automatic model_step(input bit s, input bit e, input bit m, input bit d);
        exp_t x;
        if (!m_play && !m_fin) begin
            x.seg = 7'b1111111;
            x.dpt = 1'b1;
        end else begin
            x.seg = pat[digits[m_idx]];
            x.dpt = (m_idx == (m_ddir ? 0 : STEPS - 1)) ? 1'b0 : 1'b1;
        end
        if (s) begin
            m_play = 1; m_fin = 0; m_el = 0; m_ddir = d;
            m_idx  = d ? STEPS - 1 : 0;
        end else if (m_play && e) begin
            m_el++;
            if (m_el == DIV) begin
                m_el   = 0;
                m_ddir = d;
                if (m_idx == (d ? 0 : STEPS - 1)) begin
                    if (m) begin m_play = 0; m_fin = 1; end
                    else m_idx = d ? STEPS - 1 : 0;
                end else begin
                    m_idx = d ? m_idx - 1 : m_idx + 1;
                end
            end
        end
        x.count = CNT_W'(m_idx);
        x.done  = m_fin;
        q.push_back(x);
    endtask

    task automatic cycle(input bit s, input bit e, input bit m, input bit d);
        @(negedge clk);
        start = s; en = e; mode = m; dir = d;
        model_step(s, e, m, d);
    endtask

    task automatic run_until(input int idx, input int el, input bit m, input bit d, input string nm);
        bit hit = 0;
        for (int i = 0; i < 100; i++) begin
            if (m_play && m_idx == idx && (el < 0 || m_el == el)) begin
                hit = 1;
                break;
            end
            cycle(0, 1, m, d);
        end
        if (!hit) begin
            compared++;
            mismatched++;
            $display("FAIL %s: step %0d not reached within 100 cycles", nm, idx);
        end
    endtask

    task automatic async_reset(input string nm);
        exp_t r;
        r.count = '0; r.seg = 7'b1111111; r.dpt = 1'b1; r.done = 1'b0;
        @(negedge clk);
        start = 0;
        #1 rst = 1'b1;
        #1 compare(nm, r);
        #1 rst = 1'b0;
        model_reset();
    endtask

    // Monitor: every rising edge presents a new output set
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) compare("cycle", q.pop_front());
    end

    initial begin
        exp_t r;
        bit   rm, rd;
        rst = 1'b1; start = 0; en = 0; mode = 0; dir = 0;
        r.count = '0; r.seg = 7'b1111111; r.dpt = 1'b1; r.done = 1'b0;
        #2 compare("reset", r);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) cycle(0, 1, 0, 0);

        // loop up, one-shot with hold and restart, loop down
        cycle(1, 1, 0, 0);
        repeat (30) cycle(0, 1, 0, 0);
        cycle(1, 1, 1, 0);
        repeat (45) cycle(0, 1, 1, 0);
        cycle(1, 1, 1, 0);
        repeat (6) cycle(0, 1, 1, 0);
        cycle(1, 1, 0, 1);
        repeat (30) cycle(0, 1, 0, 1);

        // enable freeze mid-step 2
        cycle(1, 1, 0, 0);
        run_until(2, 1, 0, 0, "freeze_wait");
        repeat (10) cycle(0, 0, 0, 0);
        repeat (12) cycle(0, 1, 0, 0);

        // start coincident with the tick leaving step 3
        cycle(1, 1, 0, 0);
        run_until(3, DIV - 1, 0, 0, "tick_wait");
        cycle(1, 1, 0, 0);
        repeat (8) cycle(0, 1, 0, 0);

        // asynchronous reset at step 4, then idle until start
        run_until(4, -1, 0, 0, "rst_wait");
        async_reset("async_rst");
        repeat (10) cycle(0, 1, 0, 0);
        cycle(1, 1, 1, 1);
        repeat (30) cycle(0, 1, 1, 1);

        // randomized traffic
        rm = 0; rd = 0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 29) == 0) rm = ~rm;
            if ($urandom_range(0, 19) == 0) rd = ~rd;
            cycle($urandom_range(0, 39) == 0, $urandom_range(0, 9) != 0, rm, rd);
            if ($urandom_range(0, 499) == 0) async_reset("rand_rst");
        end

        @(negedge clk);
        start = 0;
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
